// File: rtl/muldiv_sequencer_if.sv
// Issue/result bundle between execute-stage control and the mul/div sequencer.
// Handshake: the op is accepted at the clk edge where start=1 and flush=0 while
// busy=0. done is a single-cycle pulse after hi/lo have taken the new result.
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [5:0]       func;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             flush;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [2:0]       state_dbg;

  modport master (
    output start, func, rs_val, rt_val, flush,
    input  busy, done, div_by_zero, hi, lo, state_dbg
  );

  modport slave (
    input  start, func, rs_val, rt_val, flush,
    output busy, done, div_by_zero, hi, lo, state_dbg
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO: magnitude prep,
// 32 shift-add or restoring shift-subtract steps, then sign fix-up.
module muldiv_sequencer #(
  parameter int WIDTH  = 32,
  parameter int ITER_W = 6
) (
  input  logic              clk,
  input  logic              rst_b,
  muldiv_sequencer_if.slave bus
);
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ITER_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]    a_q, a_d;
  logic [WIDTH-1:0]    b_q, b_d;
  logic                is_div_q, is_div_d;
  logic                is_sgn_q, is_sgn_d;
  logic                neg_q, neg_d;
  logic                rneg_q, rneg_d;
  logic                dz_q, dz_d;
  logic [WIDTH-1:0]    hi_q, hi_d;
  logic [WIDTH-1:0]    lo_q, lo_d;

  logic                accept;
  logic                is_muldiv;
  logic                a_neg, b_neg;
  logic [WIDTH-1:0]    a_mag, b_mag;
  logic [WIDTH:0]      mul_sum;
  logic [WIDTH:0]      div_trial;
  logic [WIDTH:0]      div_diff;
  logic [2*WIDTH-1:0]  mul_next;
  logic [2*WIDTH-1:0]  div_next;
  logic [2*WIDTH-1:0]  prod_fix;
  logic [WIDTH-1:0]    quo, rem;

  // acc holds {partial product, remaining multiplier} or {remainder, quotient}
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                     {1'b0, (acc_q[0] ? a_q : {WIDTH{1'b0}})};
  assign mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
  assign div_trial = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_trial - {1'b0, b_q};
  assign div_next  = {(div_diff[WIDTH] ? div_trial[WIDTH-1:0] : div_diff[WIDTH-1:0]),
                      acc_q[WIDTH-2:0], ~div_diff[WIDTH]};

  assign a_neg = is_sgn_q & a_q[WIDTH-1];
  assign b_neg = is_sgn_q & b_q[WIDTH-1];
  assign a_mag = a_neg ? (~a_q + 1'b1) : a_q;
  assign b_mag = b_neg ? (~b_q + 1'b1) : b_q;

  assign prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
  // Divide-by-zero keeps the all-ones quotient regardless of operand signs
  assign quo = (neg_q && !dz_q) ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
  assign rem = rneg_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];

  assign accept    = bus.start && !bus.flush && (state_q == IDLE || state_q == DONE);
  assign is_muldiv = (bus.func == F_MULT) || (bus.func == F_MULTU) ||
                     (bus.func == F_DIV)  || (bus.func == F_DIVU);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    a_d      = a_q;
    b_d      = b_q;
    is_div_d = is_div_q;
    is_sgn_d = is_sgn_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          if (is_muldiv) begin
            state_d  = PREP;
            a_d      = bus.rs_val;
            b_d      = bus.rt_val;
            is_div_d = bus.func[1];
            is_sgn_d = ~bus.func[0];
          end else if (bus.func == F_MTHI) begin
            hi_d = bus.rs_val;
          end else if (bus.func == F_MTLO) begin
            lo_d = bus.rs_val;
          end
        end
      end
      PREP: begin
        a_d     = a_mag;
        b_d     = b_mag;
        neg_d   = a_neg ^ b_neg;
        rneg_d  = a_neg;
        dz_d    = is_div_q && (b_q == '0);
        acc_d   = {{WIDTH{1'b0}}, (is_div_q ? a_mag : b_mag)};
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ITER_W'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        if (is_div_q) begin
          lo_d = quo;
          hi_d = rem;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        cnt_d   = '0;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    // A squash abandons the op before it can touch HI/LO
    if (bus.flush && (state_q == PREP || state_q == RUN || state_q == FIX)) begin
      state_d = IDLE;
      cnt_d   = '0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      is_div_q <= 1'b0;
      is_sgn_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      is_div_q <= is_div_d;
      is_sgn_q <= is_sgn_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign bus.busy        = (state_q == PREP) || (state_q == RUN) || (state_q == FIX);
  assign bus.done        = (state_q == DONE);
  assign bus.div_by_zero = (state_q == DONE) && dz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.state_dbg   = state_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: latency, results, div-by-zero,
// ignored starts, flush, MTHI/MTLO and mid-run reset.
module tb_muldiv_sequencer;
  localparam int W = 32;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  logic clk;
  logic rst_b;
  int   checks = 0;
  int   errors = 0;

  muldiv_sequencer_if #(.WIDTH(W)) bus ();

  muldiv_sequencer #(.WIDTH(W), .ITER_W(6)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start  = 1'b1;
    bus.func   = f;
    bus.rs_val = a;
    bus.rt_val = b;
    tick();
    bus.start  = 1'b0;
  endtask

  // Called right after the accepting edge; returns edges until done and busy samples seen.
  task automatic wait_done(output int lat, output int busy_cnt, output int dbz_early);
    lat = 0; busy_cnt = 0; dbz_early = 0;
    while (bus.done !== 1'b1 && lat < 100) begin
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.div_by_zero !== 1'b0) dbz_early++;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    tick(); tick();
    rst_b = 1'b1;
    checks++; if (bus.state_dbg !== 3'd0) begin $display("FAIL reset_state got=%0d exp=0", bus.state_dbg); errors++; end
    checks++; if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000) begin $display("FAIL reset_flags got=%b exp=000", {bus.busy, bus.done, bus.div_by_zero}); errors++; end
    checks++; if ({bus.hi, bus.lo} !== 64'h0) begin $display("FAIL reset_hilo got=%h exp=0", {bus.hi, bus.lo}); errors++; end
  endtask

  task automatic test_mult();
    int lat, bc, de;
    issue(F_MULT, 32'hFFFF_FFFD, 32'd7);
    wait_done(lat, bc, de);
    checks++; if (lat !== 34) begin $display("FAIL mult_latency got=%0d exp=34", lat); errors++; end
    checks++; if (bc !== 34) begin $display("FAIL mult_busy_cycles got=%0d exp=34", bc); errors++; end
    checks++; if ({bus.hi, bus.lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin $display("FAIL mult_result got=%h exp=ffffffffffffffeb", {bus.hi, bus.lo}); errors++; end
    checks++; if (bus.div_by_zero !== 1'b0) begin $display("FAIL mult_dbz got=%b exp=0", bus.div_by_zero); errors++; end
    tick();
    checks++; if (bus.done !== 1'b0 || bus.state_dbg !== 3'd0) begin $display("FAIL mult_done_pulse got=%b/%0d exp=0/0", bus.done, bus.state_dbg); errors++; end
  endtask

  task automatic test_back_to_back();
    int lat, bc, de;
    issue(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(lat, bc, de);
    checks++; if ({bus.hi, bus.lo} !== 64'hFFFF_FFFE_0000_0001) begin $display("FAIL multu_result got=%h exp=fffffffe00000001", {bus.hi, bus.lo}); errors++; end
    issue(F_DIV, 32'hFFFF_FFF9, 32'd2);
    checks++; if (bus.busy !== 1'b1 || bus.state_dbg !== 3'd1) begin $display("FAIL b2b_accept got=%b/%0d exp=1/1", bus.busy, bus.state_dbg); errors++; end
    wait_done(lat, bc, de);
    checks++; if (lat + 1 !== 35) begin $display("FAIL b2b_spacing got=%0d exp=35", lat + 1); errors++; end
    checks++; if (bus.lo !== 32'hFFFF_FFFD || bus.hi !== 32'hFFFF_FFFF) begin $display("FAIL div_neg7_2 got=%h/%h exp=fffffffd/ffffffff", bus.lo, bus.hi); errors++; end
    tick();
  endtask

  task automatic test_div_zero();
    int lat, bc, de;
    issue(F_DIVU, 32'd100, 32'd0);
    wait_done(lat, bc, de);
    checks++; if (lat !== 34) begin $display("FAIL divu0_latency got=%0d exp=34", lat); errors++; end
    checks++; if (de !== 0 || bus.div_by_zero !== 1'b1) begin $display("FAIL divu0_flag got=early%0d/%b exp=early0/1", de, bus.div_by_zero); errors++; end
    checks++; if (bus.lo !== 32'hFFFF_FFFF || bus.hi !== 32'd100) begin $display("FAIL divu0_result got=%h/%h exp=ffffffff/00000064", bus.lo, bus.hi); errors++; end
    tick();
    checks++; if (bus.div_by_zero !== 1'b0) begin $display("FAIL divu0_flag_drop got=%b exp=0", bus.div_by_zero); errors++; end
    issue(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(lat, bc, de);
    checks++; if (bus.lo !== 32'h8000_0000 || bus.hi !== 32'h0) begin $display("FAIL div_ovf got=%h/%h exp=80000000/00000000", bus.lo, bus.hi); errors++; end
    checks++; if (bus.div_by_zero !== 1'b0) begin $display("FAIL div_ovf_flag got=%b exp=0", bus.div_by_zero); errors++; end
    tick();
  endtask

  task automatic test_ignore_and_flush();
    int lat, bc, de;
    bit saw_done;
    issue(F_MULT, 32'd5, 32'd6);
    for (int i = 0; i < 9; i++) tick();
    issue(F_DIV, 32'd1000, 32'd3);
    wait_done(lat, bc, de);
    checks++; if (lat + 10 !== 34) begin $display("FAIL ignore_latency got=%0d exp=34", lat + 10); errors++; end
    checks++; if (bus.hi !== 32'd0 || bus.lo !== 32'd30) begin $display("FAIL ignore_result got=%h/%h exp=00000000/0000001e", bus.hi, bus.lo); errors++; end
    tick();
    issue(F_MULTU, 32'd123, 32'd456);
    for (int i = 0; i < 11; i++) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    checks++; if (bus.state_dbg !== 3'd0 || bus.busy !== 1'b0) begin $display("FAIL flush_idle got=%0d/%b exp=0/0", bus.state_dbg, bus.busy); errors++; end
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) saw_done = 1'b1;
      tick();
    end
    checks++; if (saw_done !== 1'b0) begin $display("FAIL flush_no_done got=%b exp=0", saw_done); errors++; end
    checks++; if (bus.hi !== 32'd0 || bus.lo !== 32'd30) begin $display("FAIL flush_hilo got=%h/%h exp=00000000/0000001e", bus.hi, bus.lo); errors++; end
  endtask

  task automatic test_mthi_mtlo();
    issue(F_MTHI, 32'h1234_5678, 32'h0);
    checks++; if (bus.hi !== 32'h1234_5678 || bus.lo !== 32'd30) begin $display("FAIL mthi got=%h/%h exp=12345678/0000001e", bus.hi, bus.lo); errors++; end
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.state_dbg !== 3'd0) begin $display("FAIL mthi_flags got=%b%b/%0d exp=00/0", bus.busy, bus.done, bus.state_dbg); errors++; end
    bus.flush = 1'b1;
    issue(F_MTLO, 32'hDEAD_BEEF, 32'h0);
    bus.flush = 1'b0;
    checks++; if (bus.lo !== 32'd30 || bus.hi !== 32'h1234_5678) begin $display("FAIL mtlo_flushed got=%h/%h exp=0000001e/12345678", bus.lo, bus.hi); errors++; end
    issue(F_MTLO, 32'hCAFE_F00D, 32'h0);
    checks++; if (bus.lo !== 32'hCAFE_F00D || bus.hi !== 32'h1234_5678) begin $display("FAIL mtlo got=%h/%h exp=cafef00d/12345678", bus.lo, bus.hi); errors++; end
    issue(6'b100000, 32'h5555_5555, 32'h1);
    checks++; if (bus.state_dbg !== 3'd0 || bus.lo !== 32'hCAFE_F00D || bus.hi !== 32'h1234_5678) begin $display("FAIL bad_func got=%0d/%h/%h exp=0/cafef00d/12345678", bus.state_dbg, bus.lo, bus.hi); errors++; end
  endtask

  task automatic test_reset_mid_run();
    bit saw_done;
    issue(F_MULTU, 32'd9, 32'd9);
    for (int i = 0; i < 10; i++) tick();
    checks++; if (bus.state_dbg !== 3'd2) begin $display("FAIL pre_reset_run got=%0d exp=2", bus.state_dbg); errors++; end
    rst_b = 1'b0;
    tick();
    rst_b = 1'b1;
    checks++; if (bus.state_dbg !== 3'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin $display("FAIL midrun_reset got=%0d/%b%b exp=0/00", bus.state_dbg, bus.busy, bus.done); errors++; end
    checks++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin $display("FAIL midrun_reset_hilo got=%h/%h exp=0/0", bus.hi, bus.lo); errors++; end
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) saw_done = 1'b1;
      tick();
    end
    checks++; if (saw_done !== 1'b0) begin $display("FAIL midrun_no_done got=%b exp=0", saw_done); errors++; end
  endtask

  initial begin
    rst_b      = 1'b0;
    bus.start  = 1'b0;
    bus.func   = 6'h0;
    bus.rs_val = '0;
    bus.rt_val = '0;
    bus.flush  = 1'b0;
    test_reset();
    test_mult();
    test_back_to_back();
    test_div_zero();
    test_ignore_and_flush();
    test_mthi_mtlo();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle multiply/divide controller sitting beside the single-cycle ALU in the execute stage. It owns the architectural HI/LO registers.
- Takes MULT, MULTU, DIV, DIVU, MTHI and MTLO off the ALU path and sequences a 32-iteration shift-add multiply or restoring divide.
- Exposes a busy/done handshake so the pipeline control stalls dependent MFHI/MFLO and further mul/div issue.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- ITER_W, 6, width of the iteration counter; must hold WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_b  input  1  synchronous active-low reset
- start  input  1  issue request, sampled on the clk edge
- func  input  6  op select: 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU, 010001 MTHI, 010011 MTLO
- rs_val  input  WIDTH  operand A (multiplicand, dividend, or MTHI/MTLO source)
- rt_val  input  WIDTH  operand B (multiplier or divisor)
- flush  input  1  abort the in-flight op (pipeline squash)
- busy  output  1  op in progress; new start ignored
- done  output  1  one-cycle pulse: HI/LO hold the new result
- div_by_zero  output  1  pulses with done when a DIV/DIVU had rt_val == 0
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (rst_b low at an edge, any state, including mid-operation): state=IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0, counter=0.
- States: IDLE, PREP, RUN, FIX, DONE.
- busy=1 exactly in PREP, RUN and FIX. done=1 only in DONE. div_by_zero is asserted only in DONE.
- Accepting a start:
  - Accepted only when state is IDLE or DONE. start while busy is ignored, with no side effects.
  - start with MULT/MULTU/DIV/DIVU captures rs_val, rt_val, func, and sign flags (signed ops only): next state PREP.
  - start with MTHI/MTLO writes hi or lo from rs_val at that edge. The other register is unchanged; no busy, no done; next state IDLE.
  - start with any other func is ignored: next state IDLE.
- PREP (1 cycle): take magnitudes of signed operands and record the result sign. For DIV, the remainder takes the dividend's sign. Clear the accumulator; counter=0.
- RUN (WIDTH cycles):
  - Multiply: one shift-add step per cycle into a 2*WIDTH accumulator.
  - Divide: one restoring shift-subtract step per cycle.
  - counter increments each cycle; after the step with counter==WIDTH-1, go to FIX.
- FIX (1 cycle): apply two's-complement sign correction, then write hi/lo.
  - MULT/MULTU: {hi,lo} = 64-bit product.
  - DIV/DIVU: lo = quotient (truncated toward zero), hi = remainder.
- DONE (1 cycle): done=1. Next state is PREP if an accepted mul/div start is present; otherwise IDLE (or IDLE after an MTHI/MTLO write).
- Latency: start accepted at edge E0. HI/LO are updated at edge E0+WIDTH+2, and done is high in the cycle after it (E0+34 for WIDTH=32). Back-to-back throughput is one op per WIDTH+3 cycles.
- Divide by zero (rt_val==0): the iterations still run. Result is lo=all ones, hi=rs_val (unsigned magnitude re-signed as the dividend), and div_by_zero=1 with done.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0, no flag.
- flush:
  - In PREP, RUN or FIX: go to IDLE next cycle, hi/lo unchanged, no done.
  - In IDLE or DONE: no effect on state, but a same-cycle start is ignored.
  - flush has priority over start.
- hi and lo change only at FIX, on an MTHI/MTLO write, or at reset.

Test Plan:
- Reset, then MULT rs=0xFFFFFFFD (-3), rt=7 → busy for 34 cycles; done pulse at E0+34; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Immediately follow with DIV -7/2 (start held during done) → lo=0xFFFFFFFD, hi=0xFFFFFFFF; second done exactly 35 cycles after the first.
- DIVU 100/0 → lo=0xFFFFFFFF, hi=100, div_by_zero=1 only in the done cycle. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0, div_by_zero=0.
- MULT 5×6 running, second start (DIV) at cycle 10 → ignored; result hi=0, lo=30. A flush at cycle 12 of a later op → IDLE next cycle, no done, hi/lo keep 0/30.
- MTHI rs=0x12345678 in IDLE → hi=0x12345678 next cycle, lo unchanged, busy/done stay 0. MTLO with flush asserted in the same cycle → lo unchanged.
- rst_b low during RUN → next cycle state IDLE, hi=lo=0, busy=0, no done pulse.
